// File: rtl/jtag_vio_drv.sv
// -----------------------------------------------------------------------------
// jtag_vio_drv
//
// Host-to-design virtual output driver on the GW_JTAG ER1 user chain.
// The JTAG user-register signals are oversampled on the system clock. A
// WIDTH-bit word is shifted in from TDI, LSB first, and committed to probe_o
// on Update-DR. The word captured from probe_in_i at Capture-DR is shifted
// out on TDO, LSB first, as readback.
//
// Ports
//   clk_i                 system clock (ex_clk_27m domain)
//   rst_n_i               asynchronous active-low reset
//   tck_i, tdi_i          JTAG TCK / TDI, asynchronous to clk_i
//   enable_i              ER1 selected
//   shift_dr_capture_dr_i Capture-DR / Shift-DR active
//   update_dr_i           Update-DR
//   test_logic_reset_i    TAP in Test-Logic-Reset
//   probe_in_i            readback word, loaded at Capture-DR
//   tdo_o                 serial readback, LSB first, registered
//   probe_o               committed host word
//   probe_strobe_o        1-cycle pulse when probe_o is updated
//   len_err_o             1-cycle pulse when an update is rejected for bit count
// -----------------------------------------------------------------------------
module jtag_vio_drv #(
    parameter int                 WIDTH       = 32,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             tck_i,
    input  logic             tdi_i,
    input  logic             enable_i,
    input  logic             shift_dr_capture_dr_i,
    input  logic             update_dr_i,
    input  logic             test_logic_reset_i,
    input  logic [WIDTH-1:0] probe_in_i,
    output logic             tdo_o,
    output logic [WIDTH-1:0] probe_o,
    output logic             probe_strobe_o,
    output logic             len_err_o
);

    // Counter is one bit wider than needed for WIDTH+1 so saturation at
    // WIDTH+1 can never wrap back to a legal count.
    localparam int            CW        = $clog2(WIDTH + 1) + 1;
    localparam logic [CW-1:0] CNT_FULL  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_MAX   = CW'(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam int            NSYNC     = 6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_WAIT_UPD = 2'd2
    } state_t;

    // Saturating increment of the bit counter.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    // Synchroniser bit lanes: 0 tck, 1 tdi, 2 enable, 3 sdc, 4 update, 5 tlr.
    logic [SYNC_STAGES-1:0][NSYNC-1:0] sync_r;
    logic [NSYNC-1:0]                  raw_s;
    logic [NSYNC-1:0]                  synced_s;

    logic             tck_s;
    logic             tdi_s;
    logic             en_s;
    logic             sdc_s;
    logic             upd_s;
    logic             srst_s;
    logic             tck_prev_r;
    logic             upd_prev_r;
    logic             tck_rise_s;
    logic             upd_rise_s;

    state_t           state_r;
    logic [WIDTH-1:0] sr_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] probe_r;
    logic             probe_strobe_r;
    logic             len_err_r;
    logic             tdo_r;

    assign raw_s    = {test_logic_reset_i, update_dr_i, shift_dr_capture_dr_i,
                       enable_i, tdi_i, tck_i};
    assign synced_s = sync_r[SYNC_STAGES-1];

    assign tck_s  = synced_s[0];
    assign tdi_s  = synced_s[1];
    assign en_s   = synced_s[2];
    assign sdc_s  = synced_s[3];
    assign upd_s  = synced_s[4];
    // TAP Test-Logic-Reset acts as a synchronous soft reset of the FSM.
    assign srst_s = synced_s[5];

    assign tck_rise_s = tck_s & ~tck_prev_r;
    assign upd_rise_s = upd_s & ~upd_prev_r & en_s;

    // Multi-stage synchroniser for all asynchronous JTAG inputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_r <= {(SYNC_STAGES*NSYNC){1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw_s};
        end
    end

    // Delayed copies of synced TCK and Update-DR for rising-edge detection.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tck_prev_r <= 1'b0;
            upd_prev_r <= 1'b0;
        end else begin
            tck_prev_r <= tck_s;
            upd_prev_r <= upd_s;
        end
    end

    // Capture/shift/update FSM with shift register, counter and probe outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r        <= ST_IDLE;
            sr_r           <= {WIDTH{1'b0}};
            cnt_r          <= CNT_ZERO;
            probe_r        <= RESET_VALUE;
            probe_strobe_r <= 1'b0;
            len_err_r      <= 1'b0;
        end else begin
            probe_strobe_r <= 1'b0;
            len_err_r      <= 1'b0;
            if (srst_s) begin
                // TAP reset abandons any transfer but keeps the committed word.
                state_r <= ST_IDLE;
                cnt_r   <= CNT_ZERO;
            end else if (upd_rise_s && (state_r == ST_WAIT_UPD)) begin
                if (cnt_r == CNT_FULL) begin
                    probe_r        <= sr_r;
                    probe_strobe_r <= 1'b1;
                end else begin
                    len_err_r      <= 1'b1;
                end
                state_r <= ST_IDLE;
            end else if (tck_rise_s) begin
                if (!en_s) begin
                    state_r <= ST_IDLE;
                end else begin
                    case (state_r)
                        ST_IDLE: begin
                            // Capture-DR edge: load readback, shift nothing.
                            if (sdc_s) begin
                                sr_r    <= probe_in_i;
                                cnt_r   <= CNT_ZERO;
                                state_r <= ST_SHIFT;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end
                        ST_SHIFT: begin
                            // The edge leaving Shift-DR still has sdc high, so
                            // the Exit1 transition shifts its bit here.
                            if (sdc_s) begin
                                sr_r  <= {tdi_s, sr_r[WIDTH-1:1]};
                                cnt_r <= sat_inc(cnt_r);
                            end else begin
                                state_r <= ST_WAIT_UPD;
                            end
                        end
                        ST_WAIT_UPD: begin
                            // Back into Shift-DR from Pause/Exit2: continue the
                            // same word without reloading readback data.
                            if (sdc_s) begin
                                sr_r    <= {tdi_s, sr_r[WIDTH-1:1]};
                                cnt_r   <= sat_inc(cnt_r);
                                state_r <= ST_SHIFT;
                            end else begin
                                state_r <= ST_WAIT_UPD;
                            end
                        end
                        default: begin
                            state_r <= ST_IDLE;
                        end
                    endcase
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Registered TDO follows the shift register LSB one cycle later.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tdo_r <= 1'b0;
        end else begin
            tdo_r <= sr_r[0];
        end
    end

    assign tdo_o          = tdo_r;
    assign probe_o        = probe_r;
    assign probe_strobe_o = probe_strobe_r;
    assign len_err_o      = len_err_r;

endmodule
